// File: rtl/trap_sequencer.sv
// trap_sequencer: multi-cycle M-mode trap/mret sequencer driving the CSR write port and PC redirect
module trap_sequencer #(
  parameter int XLEN = 64,
  parameter logic [11:0] MTVEC_ADDR = 12'h305,
  parameter logic [11:0] MEPC_ADDR = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR = 12'h342,
  parameter logic [11:0] MTVAL_ADDR = 12'h343,
  parameter logic [11:0] MSTATUS_ADDR = 12'h300
) (
  input  logic clk,
  input  logic reset,
  input  logic valid,
  input  logic [2:0] exceptSignal,
  input  logic trapReturn,
  input  logic [XLEN-1:0] excPC,
  input  logic [31:0] excInstr,
  input  logic [XLEN-1:0] csrMtvec,
  input  logic [XLEN-1:0] csrMepc,
  input  logic [XLEN-1:0] csrMstatus,
  output logic busy,
  output logic flush,
  output logic pcLoad,
  output logic [XLEN-1:0] pcTarget,
  output logic csrWe,
  output logic [11:0] csrWAddr,
  output logic [XLEN-1:0] csrWData,
  output logic [1:0] privMode
);
  localparam logic [2:0] IDLE = 3'd0, T_EPC = 3'd1, T_CAUSE = 3'd2, T_TVAL = 3'd3,
                         T_STATUS = 3'd4, T_JUMP = 3'd5, R_STATUS = 3'd6, R_JUMP = 3'd7;
  logic [2:0] state;
  logic [XLEN-1:2] pc_q, mtvec_q, mepc_q;
  logic [3:0] cause_q, cause_d;
  logic [XLEN-1:0] tval_q, tval_d, mstatus_q, st_trap, st_ret;
  logic trig, trap, unused_bits;
  assign trig = state == IDLE && valid && (|exceptSignal || trapReturn);
  // mret outside M mode falls through to the illegal-instruction path
  assign trap = |exceptSignal || privMode != 2'b11;
  assign cause_d = exceptSignal[2] ? 4'd2 : exceptSignal[0] ? 4'd3 :
                   exceptSignal[1] ? {2'b10, privMode} : 4'd2;
  assign tval_d = exceptSignal[2] ? {{(XLEN-32){1'b0}}, excInstr} : exceptSignal[0] ? excPC :
                  exceptSignal[1] ? '0 : {{(XLEN-32){1'b0}}, excInstr};
  assign unused_bits = ^{csrMtvec[1:0], csrMepc[1:0], MTVEC_ADDR};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      privMode <= 2'b11;
      pc_q <= '0;
      mtvec_q <= '0;
      mepc_q <= '0;
      cause_q <= '0;
      tval_q <= '0;
      mstatus_q <= '0;
    end else begin
      if (trig) begin
        state <= trap ? T_EPC : R_STATUS;
        pc_q <= excPC[XLEN-1:2];
        mtvec_q <= csrMtvec[XLEN-1:2];
        mepc_q <= csrMepc[XLEN-1:2];
        cause_q <= cause_d;
        tval_q <= tval_d;
        mstatus_q <= csrMstatus;
      end else if (state == T_JUMP || state == R_JUMP) state <= IDLE;
      else if (state != IDLE) state <= state + 3'd1;
      if (state == T_STATUS) privMode <= 2'b11;
      if (state == R_STATUS) privMode <= mstatus_q[12:11] == 2'b11 ? 2'b11 : 2'b00;
    end
  end
  always_comb begin
    st_trap = mstatus_q;
    st_trap[7] = mstatus_q[3];
    st_trap[3] = 1'b0;
    st_trap[12:11] = privMode;
    st_ret = mstatus_q;
    st_ret[3] = mstatus_q[7];
    st_ret[7] = 1'b1;
    st_ret[12:11] = 2'b00;
  end
  assign busy = trig || state != IDLE;
  assign flush = trig;
  assign pcLoad = state == T_JUMP || state == R_JUMP;
  assign pcTarget = state == T_JUMP ? {mtvec_q, 2'b00} : state == R_JUMP ? {mepc_q, 2'b00} : '0;
  assign csrWe = (state >= T_EPC && state <= T_STATUS) || state == R_STATUS;
  assign csrWAddr = state == T_EPC ? MEPC_ADDR : state == T_CAUSE ? MCAUSE_ADDR :
                    state == T_TVAL ? MTVAL_ADDR :
                    (state == T_STATUS || state == R_STATUS) ? MSTATUS_ADDR : 12'h000;
  assign csrWData = state == T_EPC ? {pc_q, 2'b00} :
                    state == T_CAUSE ? {{(XLEN-4){1'b0}}, cause_q} :
                    state == T_TVAL ? tval_q : state == T_STATUS ? st_trap :
                    state == R_STATUS ? st_ret : '0;
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: vector table plus hand sequences, checked cycle by cycle through an expectation queue
module tb_trap_sequencer;
  logic clk = 1'b0;
  logic reset, valid, trapReturn, busy, flush, pcLoad, csrWe;
  logic [2:0] exceptSignal;
  logic [31:0] excInstr;
  logic [63:0] excPC, csrMtvec, csrMepc, csrMstatus, pcTarget, csrWData;
  logic [11:0] csrWAddr;
  logic [1:0] privMode;
  trap_sequencer dut (
    .clk(clk), .reset(reset), .valid(valid), .exceptSignal(exceptSignal), .trapReturn(trapReturn),
    .excPC(excPC), .excInstr(excInstr), .csrMtvec(csrMtvec), .csrMepc(csrMepc),
    .csrMstatus(csrMstatus), .busy(busy), .flush(flush), .pcLoad(pcLoad), .pcTarget(pcTarget),
    .csrWe(csrWe), .csrWAddr(csrWAddr), .csrWData(csrWData), .privMode(privMode)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic b, f, l;
    logic [63:0] t;
    logic w;
    logic [11:0] a;
    logic [63:0] d;
    logic [1:0] p;
  } obs_t;
  typedef struct {
    int kind;
    logic v;
    logic [2:0] exc;
    logic ret;
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] mtvec, mepc, ms, epc;
    logic [3:0] cause;
    logic [63:0] tval, st, tgt;
    logic [1:0] pa;
  } vec_t;
  obs_t exp_q[$];
  string name_q[$];
  vec_t vecs[13];
  int checks = 0, errors = 0;
  logic [1:0] cur_priv;
  function automatic obs_t ob(logic b, logic f, logic l, logic [63:0] t, logic w, logic [11:0] a,
                              logic [63:0] d, logic [1:0] p);
    return '{b, f, l, t, w, a, d, p};
  endfunction
  function automatic obs_t idle(logic [1:0] p);
    return ob(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 12'h0, 64'h0, p);
  endfunction
  always @(negedge clk) begin
    obs_t e, a;
    string n;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = '{busy, flush, pcLoad, pcTarget, csrWe, csrWAddr, csrWData, privMode};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got busy=%b flush=%b pcLoad=%b tgt=%h we=%b addr=%h data=%h priv=%b, expected busy=%b flush=%b pcLoad=%b tgt=%h we=%b addr=%h data=%h priv=%b",
                 n, a.b, a.f, a.l, a.t, a.w, a.a, a.d, a.p, e.b, e.f, e.l, e.t, e.w, e.a, e.d, e.p);
      end
    end
  end
  task automatic cyc(input string n, input obs_t e);
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask
  task automatic scramble();
    valid = 1'b1;
    exceptSignal = 3'b111;
    trapReturn = 1'b1;
    excPC = 64'hDEAD_BEEF_0000_0006;
    excInstr = 32'hA5A5_5A5A;
    csrMtvec = 64'hFFFF_0000_FFFF_0000;
    csrMepc = 64'h1234_5678_9ABC_DEF0;
    csrMstatus = '1;
  endtask
  task automatic run_vec(input string n, input vec_t v);
    valid = v.v;
    exceptSignal = v.exc;
    trapReturn = v.ret;
    excPC = v.pc;
    excInstr = v.instr;
    csrMtvec = v.mtvec;
    csrMepc = v.mepc;
    csrMstatus = v.ms;
    if (v.kind == 0) begin
      cyc({n, "_idle0"}, idle(cur_priv));
      cyc({n, "_idle1"}, idle(cur_priv));
      return;
    end
    cyc({n, "_trig"}, ob(1, 1, 0, 64'h0, 0, 12'h0, 64'h0, cur_priv));
    scramble();
    if (v.kind == 1) begin
      cyc({n, "_epc"}, ob(1, 0, 0, 64'h0, 1, 12'h341, v.epc, cur_priv));
      cyc({n, "_cause"}, ob(1, 0, 0, 64'h0, 1, 12'h342, {60'h0, v.cause}, cur_priv));
      cyc({n, "_tval"}, ob(1, 0, 0, 64'h0, 1, 12'h343, v.tval, cur_priv));
    end
    cyc({n, "_status"}, ob(1, 0, 0, 64'h0, 1, 12'h300, v.st, cur_priv));
    cur_priv = v.pa;
    cyc({n, "_jump"}, ob(1, 0, 1, v.tgt, 0, 12'h0, 64'h0, cur_priv));
  endtask
  initial begin
    // kind v exc ret pc instr mtvec mepc mstatus | epc cause tval status target priv_after
    vecs[0]  = '{1, 1, 3'b010, 0, 64'h80000010, 32'h00000073, 64'h80000101, 64'h0, 64'h8,
                 64'h80000010, 4'd11, 64'h0, 64'h1880, 64'h80000100, 2'b11};
    vecs[1]  = '{2, 1, 3'b000, 1, 64'h80000100, 32'h30200073, 64'h0, 64'h80000203, 64'h80,
                 64'h0, 4'd0, 64'h0, 64'h88, 64'h80000200, 2'b00};
    vecs[2]  = '{0, 0, 3'b100, 0, 64'h80000300, 32'hFFFFFFFF, 64'h0, 64'h0, 64'h0,
                 64'h0, 4'd0, 64'h0, 64'h0, 64'h0, 2'b00};
    vecs[3]  = '{1, 1, 3'b100, 0, 64'h80000400, 32'hFFFFFFFF, 64'h80000000, 64'h0, 64'h8,
                 64'h80000400, 4'd2, 64'hFFFFFFFF, 64'h80, 64'h80000000, 2'b11};
    vecs[4]  = '{2, 1, 3'b000, 1, 64'h80000000, 32'h30200073, 64'h0, 64'h80000404, 64'h0,
                 64'h0, 4'd0, 64'h0, 64'h80, 64'h80000404, 2'b00};
    vecs[5]  = '{1, 1, 3'b010, 1, 64'h80000500, 32'h00000073, 64'h80000200, 64'h0, 64'h88,
                 64'h80000500, 4'd8, 64'h0, 64'h80, 64'h80000200, 2'b11};
    vecs[6]  = '{2, 1, 3'b000, 1, 64'h80000200, 32'h30200073, 64'h0, 64'h80000600, 64'h0,
                 64'h0, 4'd0, 64'h0, 64'h80, 64'h80000600, 2'b00};
    vecs[7]  = '{1, 1, 3'b000, 1, 64'h80000604, 32'h30200073, 64'h80000300, 64'h0, 64'h88,
                 64'h80000604, 4'd2, 64'h30200073, 64'h80, 64'h80000300, 2'b11};
    vecs[8]  = '{1, 1, 3'b001, 0, 64'h80000702, 32'h00100073, 64'h80000043, 64'h0, 64'hA_00001808,
                 64'h80000700, 4'd3, 64'h80000702, 64'hA_00001880, 64'h80000040, 2'b11};
    vecs[9]  = '{2, 1, 3'b000, 1, 64'h80000040, 32'h30200073, 64'h0, 64'h80000013, 64'h1000,
                 64'h0, 4'd0, 64'h0, 64'h80, 64'h80000010, 2'b00};
    vecs[10] = '{1, 1, 3'b110, 0, 64'h80000800, 32'h12345678, 64'h80000400, 64'h0, 64'h0,
                 64'h80000800, 4'd2, 64'h12345678, 64'h0, 64'h80000400, 2'b11};
    vecs[11] = '{2, 1, 3'b000, 1, 64'h80000400, 32'h30200073, 64'h0, 64'h80000900, 64'h1888,
                 64'h0, 4'd0, 64'h0, 64'h88, 64'h80000900, 2'b11};
    vecs[12] = '{2, 1, 3'b000, 1, 64'h80000900, 32'h30200073, 64'h0, 64'h80000A00, 64'h0800,
                 64'h0, 4'd0, 64'h0, 64'h80, 64'h80000A00, 2'b00};
    reset = 1'b1;
    valid = 1'b0;
    exceptSignal = 3'b000;
    trapReturn = 1'b0;
    excPC = '0;
    excInstr = '0;
    csrMtvec = '0;
    csrMepc = '0;
    csrMstatus = '0;
    cur_priv = 2'b11;
    @(posedge clk);
    #1;
    cyc("reset", idle(2'b11));
    reset = 1'b0;
    for (int i = 0; i < 13; i++) run_vec($sformatf("v%0d", i), vecs[i]);
    // trap from U aborted by reset while the cause write is on the port
    valid = 1'b1;
    exceptSignal = 3'b010;
    trapReturn = 1'b0;
    excPC = 64'h80000B00;
    csrMtvec = 64'h80000500;
    csrMstatus = 64'h0;
    cyc("rstA_trig", ob(1, 1, 0, 64'h0, 0, 12'h0, 64'h0, 2'b00));
    scramble();
    cyc("rstA_epc", ob(1, 0, 0, 64'h0, 1, 12'h341, 64'h80000B00, 2'b00));
    reset = 1'b1;
    cyc("rstA_cause", ob(1, 0, 0, 64'h0, 1, 12'h342, 64'd8, 2'b00));
    reset = 1'b0;
    valid = 1'b0;
    exceptSignal = 3'b000;
    trapReturn = 1'b0;
    repeat (4) cyc("rstA_after", idle(2'b11));
    // mret whose privilege drop is undone by reset during the jump
    valid = 1'b1;
    trapReturn = 1'b1;
    csrMstatus = 64'h0;
    csrMepc = 64'h80000C00;
    cyc("rstB_trig", ob(1, 1, 0, 64'h0, 0, 12'h0, 64'h0, 2'b11));
    scramble();
    cyc("rstB_status", ob(1, 0, 0, 64'h0, 1, 12'h300, 64'h80, 2'b11));
    reset = 1'b1;
    cyc("rstB_jump", ob(1, 0, 1, 64'h80000C00, 0, 12'h0, 64'h0, 2'b00));
    reset = 1'b0;
    valid = 1'b0;
    exceptSignal = 3'b100;
    trapReturn = 1'b0;
    repeat (2) cyc("rstB_after", idle(2'b11));
    repeat (5) if (exp_q.size() != 0) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
